// File: rtl/cd_csr_host.sv
// cd_csr_host: CDBUS CSR initiator that polls flags, packs TX bytes into REG_TX words
// and streams RX frame words back out as bytes, with no CPU involved.
module cd_csr_host #(
    parameter logic [3:0]  REG_INT_FLAG = 4'h0,
    parameter logic [3:0]  REG_RX       = 4'h1,
    parameter logic [3:0]  REG_TX       = 4'h2,
    parameter logic [3:0]  REG_RX_CTRL  = 4'h3,
    parameter logic [3:0]  REG_TX_CTRL  = 4'h4,
    parameter int          RX_PEND_BIT  = 1,
    parameter int          TX_CLEAN_BIT = 5,
    parameter logic [31:0] RX_DONE_VAL  = 32'h2,
    parameter logic [31:0] TX_START_VAL = 32'h2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic        csr_write,
    output logic [31:0] csr_writedata,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    input  logic        rx_ready,
    output logic        tx_overflow
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] FLAG_RD    = 4'd1;
    localparam logic [3:0] FLAG_CAP   = 4'd2;
    localparam logic [3:0] TX_COLLECT = 4'd3;
    localparam logic [3:0] TX_WR      = 4'd4;
    localparam logic [3:0] TX_COMMIT  = 4'd5;
    localparam logic [3:0] RX_RD      = 4'd6;
    localparam logic [3:0] RX_CAP     = 4'd7;
    localparam logic [3:0] RX_EMIT    = 4'd8;
    localparam logic [3:0] RX_REL     = 4'd9;
    localparam logic [8:0] MAX_LEN    = 9'd258;

    logic [3:0]  state, state_n;
    logic [8:0]  tx_cnt, rx_cnt, rx_len, len_eff, rx_cnt_n;
    logic [31:0] tx_word, tx_word_n, rx_word;
    logic [1:0]  rx_lane, lane_nx;
    logic        tx_end, tx_ovf, tx_acc, tx_store, tx_close, tx_start, rx_acc, rx_start;

    always_comb begin
        tx_acc    = state == TX_COLLECT && tx_valid;
        tx_store  = tx_acc && tx_cnt < MAX_LEN;
        tx_close  = tx_acc && (tx_last || (tx_store && tx_cnt[1:0] == 2'd3));
        tx_word_n = tx_word;
        if (tx_store) tx_word_n[{tx_cnt[1:0], 3'b000} +: 8] = tx_data;
        rx_acc    = state == RX_EMIT && rx_valid && rx_ready;
        // The length byte only exists in the first word; later words reuse the held length.
        len_eff   = rx_cnt == 9'd0 ? {1'b0, csr_readdata[23:16]} + 9'd3 : rx_len;
        rx_cnt_n  = rx_cnt + 9'd1;
        lane_nx   = rx_lane + 2'd1;
        state_n   = state;
        case (state)
            IDLE:       state_n = (irq || tx_valid) ? FLAG_RD : IDLE;
            FLAG_RD:    state_n = FLAG_CAP;
            FLAG_CAP:   state_n = csr_readdata[RX_PEND_BIT] ? RX_RD :
                                  (tx_valid && csr_readdata[TX_CLEAN_BIT]) ? TX_COLLECT : IDLE;
            TX_COLLECT: state_n = tx_close ? TX_WR : TX_COLLECT;
            TX_WR:      state_n = tx_end ? TX_COMMIT : TX_COLLECT;
            TX_COMMIT:  state_n = IDLE;
            RX_RD:      state_n = RX_CAP;
            RX_CAP:     state_n = RX_EMIT;
            RX_EMIT:    state_n = !rx_acc ? RX_EMIT : rx_last ? RX_REL : rx_lane == 2'd3 ? RX_RD : RX_EMIT;
            RX_REL:     state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        tx_start  = state == FLAG_CAP && state_n == TX_COLLECT;
        rx_start  = state == FLAG_CAP && state_n == RX_RD;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            csr_address   <= '0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_writedata <= '0;
            tx_ready      <= 1'b0;
            tx_overflow   <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_last       <= 1'b0;
            tx_cnt        <= '0;
            tx_word       <= '0;
            tx_end        <= 1'b0;
            tx_ovf        <= 1'b0;
            rx_cnt        <= '0;
            rx_len        <= '0;
            rx_word       <= '0;
            rx_lane       <= '0;
        end else begin
            state         <= state_n;
            // Strobes and address are decoded from the next state so they are registered in the access cycle.
            csr_read      <= state_n == FLAG_RD || state_n == RX_RD;
            csr_write     <= state_n == TX_WR || state_n == TX_COMMIT || state_n == RX_REL;
            csr_address   <= state_n == FLAG_RD   ? REG_INT_FLAG :
                             state_n == RX_RD     ? REG_RX :
                             state_n == TX_WR     ? REG_TX :
                             state_n == TX_COMMIT ? REG_TX_CTRL :
                             state_n == RX_REL    ? REG_RX_CTRL : 4'h0;
            csr_writedata <= state_n == TX_WR     ? tx_word_n :
                             state_n == TX_COMMIT ? TX_START_VAL :
                             state_n == RX_REL    ? RX_DONE_VAL : 32'h0;
            tx_ready      <= state_n == TX_COLLECT;
            tx_overflow   <= tx_acc && !tx_store && !tx_ovf;
            if (tx_start) begin
                tx_cnt  <= '0;
                tx_word <= '0;
                tx_end  <= 1'b0;
                tx_ovf  <= 1'b0;
            end else if (state == TX_COLLECT) begin
                tx_word <= tx_close ? 32'h0 : tx_word_n;
                if (tx_store) tx_cnt <= tx_cnt + 9'd1;
                if (tx_acc && tx_last) tx_end <= 1'b1;
                if (tx_acc && !tx_store) tx_ovf <= 1'b1;
            end
            if (rx_start) rx_cnt <= '0;
            if (state == RX_CAP) begin
                rx_word  <= csr_readdata;
                rx_len   <= len_eff;
                rx_lane  <= 2'd0;
                rx_data  <= csr_readdata[7:0];
                rx_valid <= 1'b1;
                rx_last  <= rx_cnt + 9'd1 == len_eff;
            end else if (rx_acc) begin
                rx_cnt  <= rx_cnt_n;
                rx_lane <= lane_nx;
                if (state_n == RX_EMIT) begin
                    rx_data <= rx_word[{lane_nx, 3'b000} +: 8];
                    rx_last <= rx_cnt_n + 9'd1 == rx_len;
                end else begin
                    rx_valid <= 1'b0;
                    rx_last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cd_csr_host.sv
// tb_cd_csr_host: directed bench with a CSR slave model, TX frame vector table and
// hand-written RX, priority, flag-retry, overflow and reset sequences.
module tb_cd_csr_host;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq;
    logic [3:0]  csr_address;
    logic        csr_read, csr_write;
    logic [31:0] csr_readdata = '0;
    logic [31:0] csr_writedata;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0, tx_last = 1'b0, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_last, rx_ready, tx_overflow;

    cd_csr_host dut (
        .clk(clk), .reset_n(reset_n), .irq(irq),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, wn = 0, fr_n = 0, rx_ptr = 0, rel_cnt = 0, rel_cyc = 0, ovf_n = 0, gn = 0;
    int viol_rw = 0, viol_hold = 0, rx_set = 0, first_acc = 0;
    logic [3:0]  wa [0:1023];
    logic [31:0] wd [0:1023];
    logic [7:0]  gd [0:255];
    logic        gl [0:255];
    logic [31:0] rx_mem [0:15];
    logic [7:0]  txb [0:299];
    logic        tx_clean = 1'b0, stall_mode = 1'b0, rdy = 1'b1, hold = 1'b0, pend;
    logic [7:0]  hold_d = '0;
    logic [31:0] flags;

    assign pend     = rx_set > rel_cnt;
    assign irq      = pend;
    assign flags    = {26'd0, tx_clean, 3'd0, pend, 1'b0};
    assign rx_ready = stall_mode ? cyc[0] : rdy;

    // CSR slave and stream monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (csr_read && csr_write) viol_rw <= viol_rw + 1;
        if (csr_read && csr_address == 4'h0) begin
            csr_readdata <= flags;
            fr_n <= fr_n + 1;
        end else if (csr_read && csr_address == 4'h1) begin
            csr_readdata <= rx_mem[rx_ptr];
            rx_ptr <= rx_ptr + 1;
        end else if (csr_read) csr_readdata <= 32'hDEADBEEF;
        if (csr_write) begin
            wa[wn] <= csr_address;
            wd[wn] <= csr_writedata;
            wn <= wn + 1;
            if (csr_address == 4'h3) begin
                rel_cnt <= rel_cnt + 1;
                rel_cyc <= cyc;
            end
        end
        if (tx_overflow) ovf_n <= ovf_n + 1;
        if (rx_valid && rx_ready) begin
            gd[gn] <= rx_data;
            gl[gn] <= rx_last;
            gn <= gn + 1;
        end
        if (hold && !(rx_valid && rx_data == hold_d)) viol_hold <= viol_hold + 1;
        hold   <= rx_valid && !rx_ready;
        hold_d <= rx_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int cnt_wr(input int s, input logic [3:0] a);
        int c = 0;
        for (int i = s; i < wn; i++) if (wa[i] == a) c++;
        return c;
    endfunction

    function automatic logic [31:0] nth_wr(input int s, input logic [3:0] a, input int k);
        int c = 0;
        for (int i = s; i < wn; i++) if (wa[i] == a) begin
            if (c == k) return wd[i];
            c++;
        end
        return 32'hFFFFFFFF;
    endfunction

    task automatic tx_send(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_data = txb[i];
            tx_valid = 1'b1;
            tx_last = (i == n - 1);
            t = 0;
            while (!tx_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!tx_ready) begin
                tests++;
                fails++;
                $display("FAIL tx_accept: byte %0d tx_ready=%b, required 1", i, tx_ready);
                tx_valid = 1'b0;
                tx_last = 1'b0;
                return;
            end
            if (i == 0) first_acc = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last = 1'b0;
    endtask

    task automatic wait_rel(input int target);
        int t = 0;
        while (rel_cnt < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (rel_cnt < target) begin
            fails++;
            $display("FAIL rx_release_wait: releases %0d, required %0d", rel_cnt, target);
        end
    endtask

    typedef struct {
        int          n;
        logic [7:0]  base;
        int          exp_wr;
        logic [31:0] exp_last;
    } tx_vec_t;

    tx_vec_t tv [6];
    logic [7:0] exp_b [0:8];
    logic       exp_l [0:8];
    logic [49:0] outs;
    int s, g, ov;

    assign outs = {csr_address, csr_read, csr_write, csr_writedata, tx_ready,
                   rx_data, rx_valid, rx_last, tx_overflow};

    initial begin
        tv[0] = '{1, 8'h10, 1, 32'h00000010};
        tv[1] = '{3, 8'hA0, 1, 32'h00A2A1A0};
        tv[2] = '{4, 8'h20, 1, 32'h23222120};
        tv[3] = '{6, 8'h30, 2, 32'h00003534};
        tv[4] = '{8, 8'h50, 2, 32'h57565554};
        tv[5] = '{9, 8'h60, 3, 32'h00000068};
        rx_mem[0] = 32'h02020A0B; rx_mem[1] = 32'h0000DDCC;
        rx_mem[2] = 32'h06060201; rx_mem[3] = 32'h14131211; rx_mem[4] = 32'h000000A5;
        rx_mem[5] = 32'h01010B0A;
        rx_mem[6] = 32'h03033231; rx_mem[7] = 32'h00000000;

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'd0);
        reset_n = 1'b1;

        // TX frame table
        tx_clean = 1'b1;
        for (int v = 0; v < 6; v++) begin
            s = wn;
            ov = ovf_n;
            for (int i = 0; i < tv[v].n; i++) txb[i] = tv[v].base + 8'(i);
            tx_send(tv[v].n);
            repeat (8) @(negedge clk);
            check($sformatf("tx%0d_wr_count", v), 64'(cnt_wr(s, 4'h2)), 64'(tv[v].exp_wr));
            check($sformatf("tx%0d_last_word", v), 64'(nth_wr(s, 4'h2, tv[v].exp_wr - 1)), 64'(tv[v].exp_last));
            check($sformatf("tx%0d_commit", v), 64'({wa[wn-1], wd[wn-1]}), 64'({4'h4, 32'h2}));
            check($sformatf("tx%0d_no_ovf", v), 64'(ovf_n - ov), 64'd0);
        end

        // 5-byte frame with partial final word
        s = wn;
        txb[0] = 8'h11; txb[1] = 8'h22; txb[2] = 8'h33; txb[3] = 8'h44; txb[4] = 8'h55;
        tx_send(5);
        repeat (8) @(negedge clk);
        check("tx5_writes", 64'(wn - s), 64'd3);
        check("tx5_w0", 64'({wa[s], wd[s]}), 64'({4'h2, 32'h44332211}));
        check("tx5_w1", 64'({wa[s+1], wd[s+1]}), 64'({4'h2, 32'h00000055}));
        check("tx5_commit", 64'({wa[s+2], wd[s+2]}), 64'({4'h4, 32'h2}));
        check("tx5_ready_low", 64'(tx_ready), 64'd0);

        // RX: 5-byte frame across two words
        tx_clean = 1'b0;
        g = gn;
        s = wn;
        rx_set = 1;
        wait_rel(1);
        repeat (4) @(negedge clk);
        exp_b[0] = 8'h0B; exp_b[1] = 8'h0A; exp_b[2] = 8'h02; exp_b[3] = 8'h02; exp_b[4] = 8'hCC;
        check("rx1_count", 64'(gn - g), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("rx1_byte%0d", i), 64'({gl[g+i], gd[g+i]}), 64'({i == 4, exp_b[i]}));
        check("rx1_release", 64'({wa[s], wd[s], 32'(wn - s)}), 64'({4'h3, 32'h2, 32'd1}) );

        // RX: 9-byte frame over three words with rx_ready toggling
        g = gn;
        stall_mode = 1'b1;
        rx_set = 2;
        wait_rel(2);
        repeat (4) @(negedge clk);
        stall_mode = 1'b0;
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h06; exp_b[3] = 8'h06;
        exp_b[4] = 8'h11; exp_b[5] = 8'h12; exp_b[6] = 8'h13; exp_b[7] = 8'h14; exp_b[8] = 8'hA5;
        for (int i = 0; i < 9; i++) exp_l[i] = (i == 8);
        check("rx2_count", 64'(gn - g), 64'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("rx2_byte%0d", i), 64'({gl[g+i], gd[g+i]}), 64'({exp_l[i], exp_b[i]}));
        check("rx2_word_reads", 64'(rx_ptr), 64'd5);

        // Simultaneous RX pending and TX: RX frame (exactly one word) first
        tx_clean = 1'b1;
        g = gn;
        s = wn;
        rx_set = 3;
        txb[0] = 8'hE1; txb[1] = 8'hE2;
        tx_send(2);
        repeat (8) @(negedge clk);
        check("prio_rx_bytes", 64'(gn - g), 64'd4);
        check("prio_rx_last", 64'({gl[g+3], gd[g+3]}), 64'({1'b1, 8'h01}));
        check("prio_single_read", 64'(rx_ptr), 64'd6);
        check("prio_release_first", 64'(rel_cyc < first_acc), 64'd1);
        check("prio_tx_word", 64'(nth_wr(s, 4'h2, 0)), 64'h0000E2E1);

        // No TX_CLEAN: flag polling repeats with no data write, then proceeds
        tx_clean = 1'b0;
        s = wn;
        ov = fr_n;
        txb[0] = 8'h7E;
        fork
            tx_send(1);
            begin
                repeat (20) @(negedge clk);
                check("noclean_polls", 64'(fr_n - ov >= 3), 64'd1);
                check("noclean_no_write", 64'(wn - s), 64'd0);
                tx_clean = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        check("noclean_then_word", 64'(nth_wr(s, 4'h2, 0)), 64'h0000007E);

        // 260-byte frame: 258 kept, overflow pulses once, single commit
        s = wn;
        ov = ovf_n;
        for (int i = 0; i < 260; i++) txb[i] = 8'(i + 1);
        tx_send(260);
        repeat (8) @(negedge clk);
        check("ovf_tx_writes", 64'(cnt_wr(s, 4'h2)), 64'd65);
        check("ovf_word64", 64'(nth_wr(s, 4'h2, 63)), 64'h00FFFEFD);
        check("ovf_word65", 64'(nth_wr(s, 4'h2, 64)), 64'h00000201);
        check("ovf_pulses", 64'(ovf_n - ov), 64'd1);
        check("ovf_commits", 64'(cnt_wr(s, 4'h4)), 64'd1);
        check("csr_rw_overlap", 64'(viol_rw), 64'd0);
        check("rx_hold_stable", 64'(viol_hold), 64'd0);

        // Reset during RX_EMIT with rx_ready low
        tx_clean = 1'b0;
        rdy = 1'b0;
        rx_set = 4;
        for (int t = 0; t < 50 && !rx_valid; t++) @(negedge clk);
        check("rst_rx_valid_before", 64'(rx_valid), 64'd1);
        s = cnt_wr(0, 4'h3);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_outputs_zero", 64'(outs), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_no_release", 64'(cnt_wr(0, 4'h3) - s), 64'd0);
        check("rst_outputs_held", 64'(outs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
